// File: rtl/core_pkg.sv
// Shared definitions for the RV32 fetch path.
//   XLEN             : architectural register width
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one buffered {pc, instr} pair; the low two bits of both
//                      fields are implicit (PC word aligned, instr[1:0] = 2'b11)
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:2] pc;
        logic [XLEN-1:2] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a synchronous clear.
//   clk_i / rst_ni : clock, async active-low reset (pointers and count only)
//   clear_i        : drop all contents; wins over push_i / pop_i
//   push_i/wdata_i : write one entry (caller guarantees room, or a same-cycle pop)
//   pop_i          : retire the head entry (caller guarantees non-empty)
//   rdata_o        : head entry, combinational from storage
//   count_o        : occupancy, 0..DEPTH
//   full_o/empty_o : occupancy flags
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 60
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Storage carries no reset; the valid window is defined by the pointers.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // At full with a same-cycle pop, wr_ptr == rd_ptr: the head is read
    // combinationally before the edge overwrites that slot.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the I-cache and decode.
// Runs the fetch PC ahead of decode and buffers up to DEPTH {pc, instr}
// pairs; a flush discards everything buffered and redirects fetch.
//   clk_i, rst_i          : clock, async active-low reset
//   cache_blocking_n_i    : cache word valid for cache_address_o this cycle
//   cache_instr_i         : instruction [31:2]
//   cache_address_o       : registered fetch word address [31:2]
//   flush_i, flush_pc_i   : redirect request and target [31:2]
//   stall_i               : decode cannot take the head this cycle
//   valid_o, instr_o, pc_o: head entry
//   count_o, full_o       : occupancy
module fetch_queue
    import core_pkg::*;
#(
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter bit              NOP_ON_EMPTY = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cache_blocking_n_i,
    input  logic [XLEN-1:2]        cache_instr_i,
    output logic [XLEN-1:2]        cache_address_o,
    input  logic                   flush_i,
    input  logic [XLEN-1:2]        flush_pc_i,
    input  logic                   stall_i,
    output logic                   valid_o,
    output logic [XLEN-1:2]        instr_o,
    output logic [XLEN-1:2]        pc_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);

    logic [XLEN-1:2] fetch_pc_q,   fetch_pc_d;
    logic [XLEN-1:2] last_pc_q,    last_pc_d;
    logic [XLEN-1:2] last_instr_q, last_instr_d;

    logic         push, pop, empty;
    fetch_entry_t wr_entry, head;
    logic [ENTRY_W-1:0] head_raw;

    assign valid_o  = ~empty;
    assign wr_entry = '{pc: fetch_pc_q, instr: cache_instr_i};
    assign head     = fetch_entry_t'(head_raw);

    always_comb begin
        // Flush kills both sides of the queue for this cycle.
        pop  = valid_o & ~stall_i & ~flush_i;
        push = cache_blocking_n_i & ~flush_i & (~full_o | pop);

        fetch_pc_d = fetch_pc_q;
        if (flush_i)   fetch_pc_d = flush_pc_i;
        else if (push) fetch_pc_d = fetch_pc_q + 1'b1;

        // Remember the most recent head so outputs stay defined when empty.
        last_pc_d    = last_pc_q;
        last_instr_d = last_instr_q;
        if (valid_o) begin
            last_pc_d    = head.pc;
            last_instr_d = head.instr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q   <= RESET_PC[XLEN-1:2];
            last_pc_q    <= RESET_PC[XLEN-1:2];
            last_instr_q <= NOP_INSTR[XLEN-1:2];
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            last_pc_q    <= last_pc_d;
            last_instr_q <= last_instr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .clear_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_raw),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty)
    );

    assign cache_address_o = fetch_pc_q;
    assign pc_o            = valid_o ? head.pc : last_pc_q;
    assign instr_o         = valid_o ? head.instr
                           : (NOP_ON_EMPTY ? NOP_INSTR[XLEN-1:2] : last_instr_q);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import core_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cbn   = 1'b0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic [29:0]   cinstr = '0;
    logic [29:0]   fpc    = '0;
    logic [29:0]   cache_address_o, instr_o, pc_o;
    logic          valid_o, full_o;
    logic [CW-1:0] count_o;

    always #5 clk_i = ~clk_i;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_ON_EMPTY(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cache_blocking_n_i(cbn),
        .cache_instr_i(cinstr), .cache_address_o(cache_address_o),
        .flush_i(flush), .flush_pc_i(fpc), .stall_i(stall),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .count_o(count_o), .full_o(full_o)
    );

    typedef struct { logic [29:0] pc; logic [29:0] instr; } ent_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    ent_t        sb[$];      // expected heads, oldest first
    int          m_cnt  = 0; // reference occupancy
    logic [29:0] m_pc   = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched words advanced at each edge.
    task automatic model_step();
        bit p, q;
        if (flush) begin
            sb.delete();
            m_cnt = 0;
            m_pc  = fpc;
        end else begin
            p = (m_cnt > 0) && !stall;
            q = cbn && ((m_cnt < DEPTH) || p);
            if (q) begin
                sb.push_back('{pc: m_pc, instr: cinstr});
                m_pc = m_pc + 30'd1;
            end
            m_cnt = m_cnt + int'(q) - int'(p);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        if (rst_i) model_step();
    end

    // Monitor: compare presented outputs; consume the scoreboard head on a pop.
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("count", 32'(count_o), 32'(m_cnt));
            chk("valid", 32'(valid_o), 32'(m_cnt != 0));
            chk("full",  32'(full_o),  32'(m_cnt == DEPTH));
            chk("addr",  32'(cache_address_o), 32'(m_pc));
            if (m_cnt != 0) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(sb.size()), 32'(m_cnt));
                end else begin
                    chk("head_pc",    32'(pc_o),    32'(sb[0].pc));
                    chk("head_instr", 32'(instr_o), 32'(sb[0].instr));
                    if (!stall && !flush) void'(sb.pop_front());
                end
            end else begin
                chk("nop_on_empty", 32'(instr_o), 32'h4);
            end
        end
    end

    task automatic drive(input logic c, input logic s, input logic f, input logic [29:0] t);
        @(posedge clk_i);
        #1;
        cbn    = c;
        stall  = s;
        flush  = f;
        fpc    = t;
        cinstr = 30'($urandom);
    endtask

    task automatic chk_reset_vals();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_full",  32'(full_o),  32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_pc",    32'(pc_o),    32'd0);
        chk("rst_instr", 32'(instr_o), 32'h4);
        chk("rst_addr",  32'(cache_address_o), 32'd0);
    endtask

    task automatic rand_phase(input int n);
        logic [29:0] t;
        for (int i = 0; i < n; i++) begin
            t = ($urandom_range(1) == 0) ? 30'($urandom) : 30'h3FFF_FFFC + 30'($urandom_range(3));
            drive($urandom_range(2) != 0, $urandom_range(2) == 0,
                  $urandom_range(15) == 0, t);
        end
    endtask

    initial begin
        cbn    = 1'b1;
        cinstr = 30'($urandom);
        #2;
        chk_reset_vals();
        #1 rst_i = 1'b1;

        // Free-running fetch, decode always ready.
        repeat (6) drive(1'b1, 1'b0, 1'b0, '0);

        // Decode stalls until the queue fills, then drains with overlap.
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
        repeat (6) drive(1'b1, 1'b0, 1'b0, '0);

        // Empty via flush, load three entries, then redirect to 0x100.
        drive(1'b0, 1'b1, 1'b1, 30'h0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 30'h100);
        repeat (4) drive(1'b1, 1'b0, 1'b0, '0);

        // Cache bubbles with decode popping every cycle.
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            drive(1'b0, 1'b0, 1'b0, '0);
            drive(1'b0, 1'b0, 1'b0, '0);
            drive(1'b1, 1'b0, 1'b0, '0);
        end

        // Fetch PC wrap across the top of the address space.
        drive(1'b1, 1'b0, 1'b1, 30'h3FFF_FFFE);
        repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 30'h3FFF_FFFD);
        repeat (5) drive(1'b1, 1'b1, 1'b0, '0);
        repeat (8) drive(1'b1, 1'b0, 1'b0, '0);

        // Back-to-back flushes.
        drive(1'b1, 1'b0, 1'b1, 30'h200);
        drive(1'b1, 1'b0, 1'b1, 30'h300);
        repeat (4) drive(1'b1, 1'b0, 1'b0, '0);

        rand_phase(2000);

        // Asynchronous reset mid-stream with a full, stalled queue.
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        chk_reset_vals();
        sb.delete();
        m_cnt = 0;
        m_pc  = '0;
        stall = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        repeat (6) drive(1'b1, 1'b0, 1'b0, '0);

        rand_phase(1000);
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk_i);
        @(posedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-entry instruction fetch path of the 5-stage RV32 core.
- Sits between the instruction cache and the decode stage.
- Keeps the fetch PC running ahead of decode and buffers up to DEPTH fetched {pc, instr} pairs in a FIFO.
- Decouples cache blocking from decode stalls; discards all buffered and in-flight state on a taken branch/jump.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- NOP_ON_EMPTY, 1, 1 = instr_o drives the NOP encoding while the queue is empty; 0 = instr_o holds its last value.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cache_blocking_n_i  in  1  1 = cache_instr_i is valid for the current cache_address_o this cycle.
- cache_instr_i  in  30  instruction bits [31:2]; bits [1:0] are implicitly 2'b11.
- cache_address_o  out  30  fetch word address [31:2].
- flush_i  in  1  taken branch/jump from EX/MEM; redirect fetch.
- flush_pc_i  in  30  redirect target [31:2].
- stall_i  in  1  decode cannot accept the head entry this cycle.
- valid_o  out  1  head entry is valid.
- instr_o  out  30  head instruction [31:2].
- pc_o  out  30  head PC [31:2].
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- full_o  out  1  count_o == DEPTH.

Behaviour:
- Reset (rst_i low, asynchronous; also mid-operation):
  - fetch_pc = RESET_PC[31:2]; wr_ptr = rd_ptr = 0; count = 0.
  - valid_o = 0; full_o = 0; count_o = 0.
  - pc_o = RESET_PC[31:2]; instr_o = NOP[31:2] = 30'h0000_0004.
  - Any response present during reset is ignored.
- Outputs:
  - cache_address_o = fetch_pc (registered; no combinational path from flush_i).
  - valid_o = (count != 0). instr_o/pc_o come from storage[rd_ptr].
  - When empty: instr_o = NOP if NOP_ON_EMPTY, otherwise the last value.
- pop = valid_o & ~stall_i & ~flush_i.
- push = cache_blocking_n_i & ~flush_i & (~full_o | pop).
  - Push at full is legal only when a pop happens in the same cycle; count stays DEPTH.
- On push: storage[wr_ptr] <= {fetch_pc, cache_instr_i}; wr_ptr++; fetch_pc += 1 (word).
- fetch_pc holds whenever there is no push (cache blocking or queue full).
- Pointers wrap modulo DEPTH. fetch_pc wraps 30'h3FFF_FFFF -> 0 silently.
- count_next = count + push - pop.
- Latency: a word accepted in cycle N is visible at valid_o/instr_o in N+1. Throughput is 1 instr/cycle at steady state.
- Flush (highest priority; overrides stall, push and pop):
  - wr_ptr = rd_ptr = 0; count = 0; fetch_pc = flush_pc_i.
  - The response arriving in the flush cycle is discarded.
  - valid_o = 0 in N+1; cache_address_o = flush_pc_i in N+1.
  - The first valid target instruction appears at N+2 at the earliest.
- Flush simultaneous with reset: reset wins.
- Back-to-back flushes: the last target wins; each flush clears the queue again.
- No state machine beyond FIFO bookkeeping; the pipeline state is fully defined by fetch_pc, the pointers and count.

Decomposition:
- Shared package core_pkg:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
  - Typedef fetch_entry_t {pc[31:2], instr[31:2]}.
- Sub-module fetch_fifo:
  - Generic DEPTH x WIDTH synchronous FIFO with push, pop, clear, count and full.
  - Async active-low reset on pointers and count only; storage array is not reset.
- fetch_queue owns fetch_pc, flush priority and the NOP substitution.

Test Plan:
- Reset release, cache_blocking_n_i=1, stall_i=0:
  - cache_address_o = 0, 1, 2, ...
  - valid_o rises one cycle after the first accept.
  - pc_o sequence 0, 1, 2 with instr_o matching the driven words.
- stall_i=1 for 6 cycles, DEPTH=4, cache always ready:
  - count_o 1->4, then full_o=1 and cache_address_o holds at 4.
  - Release stall: entries pop in order pc 0..3; count_o holds 4 while push+pop overlap.
- Queue holds 3 entries, assert flush_i with flush_pc_i=30'h100 and cache_blocking_n_i=1:
  - Next cycle valid_o=0, count_o=0, cache_address_o=30'h100.
  - The response in the flush cycle is never seen at instr_o.
  - First new head has pc_o=30'h100.
- cache_blocking_n_i toggling 1,0,0,1 while decode pops every cycle:
  - valid_o shows the corresponding bubbles.
  - instr_o = 30'h4 (NOP) during empty cycles; no duplicate or skipped PC.
- rst_i asserted low mid-stream with full queue and stall_i=1:
  - All outputs at reset values immediately, without a clock edge.
  - After release, fetch restarts at RESET_PC.
- fetch_pc at 30'h3FFF_FFFE with 3 accepts:
  - pc_o sequence 3FFF_FFFE, 3FFF_FFFF, 0; pointer wrap is correct across DEPTH boundary.
